// File: rtl/battleship_pkg.sv
// Shared scan-code constants, board sizing and the shot-entry state type.
// Used by the shot-entry front end and its scan-code decoder.
package battleship_pkg;

   localparam int BOARD_SIZE = 10;

   localparam logic PLAYER_ONE = 1'b0;
   localparam logic PLAYER_TWO = 1'b1;

   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_ENTER = 8'h5A;
   localparam logic [7:0] SC_BKSP  = 8'h66;

   // Element i is the make code for row letter i (A..J) / column digit i (0..9)
   localparam logic [BOARD_SIZE-1:0][7:0] SC_LETTERS = {
      8'h3B, 8'h43, 8'h33, 8'h34, 8'h2B, 8'h24, 8'h23, 8'h21, 8'h32, 8'h1C
   };
   localparam logic [BOARD_SIZE-1:0][7:0] SC_DIGITS = {
      8'h46, 8'h3E, 8'h3D, 8'h36, 8'h2E, 8'h25, 8'h26, 8'h1E, 8'h16, 8'h45
   };

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      HAVE_ROW  = 2'd1,
      HAVE_BOTH = 2'd2,
      FIRE      = 2'd3
   } shot_state_t;

endpackage

// File: rtl/shot_entry_fsm_scan_decode.sv
// Combinational classifier for a PS/2 make code: row letter, column digit,
// Enter or Backspace, plus the 0-9 board index for letters and digits.
module scan_decode
   import battleship_pkg::*;
(
   input  logic [7:0] i_key_data,
   output logic       o_is_letter,
   output logic       o_is_digit,
   output logic       o_is_enter,
   output logic       o_is_bksp,
   output logic [3:0] o_index
);

   always_comb begin
      o_is_letter = 1'b0;
      o_is_digit  = 1'b0;
      o_index     = 4'd0;
      for (int i = 0; i < BOARD_SIZE; i++) begin
         if (i_key_data == SC_LETTERS[i]) begin
            o_is_letter = 1'b1;
            o_index     = 4'(i);
         end
         if (i_key_data == SC_DIGITS[i]) begin
            o_is_digit = 1'b1;
            o_index    = 4'(i);
         end
      end
      o_is_enter = (i_key_data == SC_ENTER);
      o_is_bksp  = (i_key_data == SC_BKSP);
   end

endmodule

// File: rtl/shot_entry_fsm.sv
// Turns PS/2 keystrokes (row letter, column digit, Enter) into one shot handed
// to the hit/miss decider. Optional partial-entry timeout: define SHOT_TIMEOUT_EN.
module shot_entry_fsm
   import battleship_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 27000000,
   parameter bit FIRST_PLAYER   = 1'b0
)(
   input  logic       clock27,
   input  logic       reset_n,
   input  logic       key_valid,
   input  logic [7:0] key_data,
   output logic       shot_valid,
   input  logic       shot_ready,
   output logic [3:0] shot_row,
   output logic [3:0] shot_col,
   output logic       player_turn,
   output logic       have_row,
   output logic       have_col
);

   shot_state_t r_state, w_next_state;
   logic        r_break, r_ext, w_next_break, w_next_ext;
   logic        r_valid, r_turn, r_have_row, r_have_col;
   logic [3:0]  r_row, r_col, w_next_row, w_next_col;
   logic        w_press, w_accept, w_timeout;
   logic        w_is_letter, w_is_digit, w_is_enter, w_is_bksp;
   logic [3:0]  w_index;

   scan_decode u_decode (
      .i_key_data  (key_data),
      .o_is_letter (w_is_letter),
      .o_is_digit  (w_is_digit),
      .o_is_enter  (w_is_enter),
      .o_is_bksp   (w_is_bksp),
      .o_index     (w_index)
   );

   // Releases (F0 xx) and extended keys (E0 xx, E0 F0 xx) never reach the FSM
   always_comb begin
      w_next_break = r_break;
      w_next_ext   = r_ext;
      w_press      = 1'b0;
      if (key_valid) begin
         if (key_data == SC_BREAK) begin
            w_next_break = 1'b1;
            w_next_ext   = 1'b0;
         end else if (key_data == SC_EXT) begin
            w_next_ext = 1'b1;
         end else if (r_break || r_ext) begin
            w_next_break = 1'b0;
            w_next_ext   = 1'b0;
         end else begin
            w_press = 1'b1;
         end
      end
   end

   assign w_accept = r_valid && shot_ready;

   always_comb begin
      w_next_state = r_state;
      w_next_row   = r_row;
      w_next_col   = r_col;
      case (r_state)
         IDLE: begin
            if (w_press && w_is_letter) begin
               w_next_row   = w_index;
               w_next_state = HAVE_ROW;
            end
         end
         HAVE_ROW: begin
            if (w_press && w_is_letter) begin
               w_next_row = w_index;
            end else if (w_press && w_is_digit) begin
               w_next_col   = w_index;
               w_next_state = HAVE_BOTH;
            end else if (w_press && w_is_bksp) begin
               w_next_state = IDLE;
            end
         end
         HAVE_BOTH: begin
            if (w_press && w_is_letter) begin
               w_next_row   = w_index;
               w_next_state = HAVE_ROW;
            end else if (w_press && w_is_digit) begin
               w_next_col = w_index;
            end else if (w_press && w_is_bksp) begin
               w_next_state = HAVE_ROW;
            end else if (w_press && w_is_enter) begin
               w_next_state = FIRE;
            end
         end
         FIRE: begin
            if (w_accept) begin
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
      if (w_timeout) begin
         w_next_state = IDLE;
      end
   end

`ifdef SHOT_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] r_idle_cnt;
   logic            w_partial, w_next_partial;

   assign w_partial      = (r_state == HAVE_ROW) || (r_state == HAVE_BOTH);
   assign w_next_partial = (w_next_state == HAVE_ROW) || (w_next_state == HAVE_BOTH);
   assign w_timeout      = w_partial && !key_valid
                           && (r_idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   // Idle timer restarts on every scan byte and on entering a partial entry
   always_ff @(posedge clock27 or negedge reset_n) begin
      if (!reset_n) begin
         r_idle_cnt <= '0;
      end else if (!w_partial || !w_next_partial || key_valid || w_timeout) begin
         r_idle_cnt <= '0;
      end else begin
         r_idle_cnt <= r_idle_cnt + 1'b1;
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   // Status flags and shot_valid are registered from the next state so they
   // change on the same edge as the state itself
   always_ff @(posedge clock27 or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_break    <= 1'b0;
         r_ext      <= 1'b0;
         r_row      <= 4'd0;
         r_col      <= 4'd0;
         r_valid    <= 1'b0;
         r_have_row <= 1'b0;
         r_have_col <= 1'b0;
         r_turn     <= FIRST_PLAYER;
      end else begin
         r_state    <= w_next_state;
         r_break    <= w_next_break;
         r_ext      <= w_next_ext;
         r_row      <= w_next_row;
         r_col      <= w_next_col;
         r_valid    <= (w_next_state == FIRE);
         r_have_row <= (w_next_state != IDLE);
         r_have_col <= (w_next_state == HAVE_BOTH) || (w_next_state == FIRE);
         r_turn     <= r_turn ^ w_accept;
      end
   end

   assign shot_valid  = r_valid;
   assign shot_row    = r_row;
   assign shot_col    = r_col;
   assign player_turn = r_turn;
   assign have_row    = r_have_row;
   assign have_col    = r_have_col;

endmodule

// File: tb/tb_shot_entry_fsm.sv
// Self-checking bench for shot_entry_fsm: vector table, hand-written corner
// sequences and randomized keystrokes against a keystroke-level model.
module tb_shot_entry_fsm;

   localparam int TO_CYC = 16;

   logic       clock27;
   logic       reset_n;
   logic       key_valid;
   logic [7:0] key_data;
   logic       shot_valid;
   logic       shot_ready;
   logic [3:0] shot_row;
   logic [3:0] shot_col;
   logic       player_turn;
   logic       have_row;
   logic       have_col;

   int nCompared   = 0;
   int nMismatched = 0;

   shot_entry_fsm #(
      .TIMEOUT_CYCLES (TO_CYC),
      .FIRST_PLAYER   (1'b0)
   ) dut (
      .clock27     (clock27),
      .reset_n     (reset_n),
      .key_valid   (key_valid),
      .key_data    (key_data),
      .shot_valid  (shot_valid),
      .shot_ready  (shot_ready),
      .shot_row    (shot_row),
      .shot_col    (shot_col),
      .player_turn (player_turn),
      .have_row    (have_row),
      .have_col    (have_col)
   );

   initial clock27 = 1'b0;
   always #5 clock27 = ~clock27;

   // Keystroke-level model: what the player has typed so far
   logic [7:0] letterCodes [10] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24,
                                    8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B};
   logic [7:0] digitCodes  [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                    8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
   int mRow, mCol, mIdle;
   bit mHasRow, mHasCol, mFire, mTurn, mBrk, mExt;

   typedef struct {
      bit         kv;
      logic [7:0] kd;
      bit         rdy;
      bit         eValid;
      int         eRow;
      int         eCol;
      bit         eHr;
      bit         eHc;
      bit         eTurn;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mkVec(bit kv, logic [7:0] kd, bit rdy, bit ev,
                                  int er, int ec, bit ehr, bit ehc, bit et);
      vec_t v;
      v.kv = kv; v.kd = kd; v.rdy = rdy; v.eValid = ev; v.eRow = er;
      v.eCol = ec; v.eHr = ehr; v.eHc = ehc; v.eTurn = et;
      return v;
   endfunction

   function automatic int findCode(logic [7:0] tbl [10], logic [7:0] code);
      for (int i = 0; i < 10; i++) begin
         if (tbl[i] == code) return i;
      end
      return -1;
   endfunction

   task automatic modelReset();
      mRow = 0; mCol = 0; mIdle = 0;
      mHasRow = 0; mHasCol = 0; mFire = 0; mTurn = 0; mBrk = 0; mExt = 0;
   endtask

   task automatic modelStep(bit kv, logic [7:0] kd, bit rdy);
      bit press, wasPartial, nowPartial, timedOut, accept;
      int li, di;
      press      = 0;
      timedOut   = 0;
      wasPartial = mHasRow && !mFire;
      accept     = mFire && rdy;
`ifdef SHOT_TIMEOUT_EN
      timedOut = wasPartial && !kv && (mIdle == TO_CYC - 1);
`endif
      if (kv) begin
         if (kd == 8'hF0) begin
            mBrk = 1; mExt = 0;
         end else if (kd == 8'hE0) begin
            mExt = 1;
         end else if (mBrk || mExt) begin
            mBrk = 0; mExt = 0;
         end else begin
            press = 1;
         end
      end
      if (press && !mFire) begin
         li = findCode(letterCodes, kd);
         di = findCode(digitCodes, kd);
         if (li >= 0) begin
            mRow = li; mHasRow = 1; mHasCol = 0;
         end else if (di >= 0 && mHasRow) begin
            mCol = di; mHasCol = 1;
         end else if (kd == 8'h66) begin
            if (mHasCol) mHasCol = 0;
            else mHasRow = 0;
         end else if (kd == 8'h5A && mHasCol) begin
            mFire = 1;
         end
      end
      if (accept) begin
         mFire = 0; mHasRow = 0; mHasCol = 0; mTurn = !mTurn;
      end
      if (timedOut) begin
         mHasRow = 0; mHasCol = 0;
      end
      nowPartial = mHasRow && !mFire;
      if (!nowPartial || !wasPartial || kv || timedOut) mIdle = 0;
      else mIdle++;
   endtask

   // One clock of stimulus; the model advances with the same inputs
   task automatic applyStimulus(bit kv, logic [7:0] kd, bit rdy);
      key_valid  = kv;
      key_data   = kd;
      shot_ready = rdy;
      @(posedge clock27);
      modelStep(kv, kd, rdy);
      #1;
      key_valid  = 1'b0;
      key_data   = 8'h00;
      shot_ready = 1'b0;
   endtask

   task automatic checkOutput(string name, int act, int exp);
      nCompared++;
      if (act != exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic checkModel(string tag);
      checkOutput({tag, ".valid"}, shot_valid, mFire);
      checkOutput({tag, ".row"}, shot_row, mRow);
      checkOutput({tag, ".col"}, shot_col, mCol);
      checkOutput({tag, ".have_row"}, have_row, mHasRow);
      checkOutput({tag, ".have_col"}, have_col, mHasCol && mHasRow);
      checkOutput({tag, ".turn"}, player_turn, mTurn);
   endtask

   task automatic doReset();
      reset_n = 1'b0;
      #13;
      reset_n = 1'b1;
      modelReset();
      @(negedge clock27);
   endtask

   logic [7:0] pool [16] = '{8'h1C, 8'h32, 8'h3B, 8'h24, 8'h45, 8'h16, 8'h25,
                             8'h46, 8'h5A, 8'h5A, 8'h66, 8'hF0, 8'hE0, 8'h75,
                             8'h12, 8'h5A};

   initial begin
      reset_n = 1'b0; key_valid = 1'b0; key_data = 8'h00; shot_ready = 1'b0;
      modelReset();
      #2;
      checkOutput("reset.valid", shot_valid, 0);
      checkOutput("reset.have_row", have_row, 0);
      checkOutput("reset.turn", player_turn, 0);
      doReset();

      // Basic shot A1, release filtering, hold, accept
      vecs.push_back(mkVec(1, 8'h1C, 0, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mkVec(1, 8'hF0, 0, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mkVec(1, 8'h1C, 0, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mkVec(1, 8'h16, 0, 0, 0, 1, 1, 1, 0));
      vecs.push_back(mkVec(1, 8'hF0, 0, 0, 0, 1, 1, 1, 0));
      vecs.push_back(mkVec(1, 8'h16, 0, 0, 0, 1, 1, 1, 0));
      vecs.push_back(mkVec(1, 8'h5A, 0, 1, 0, 1, 1, 1, 0));
      for (int i = 0; i < 5; i++) vecs.push_back(mkVec(0, 8'h00, 0, 1, 0, 1, 1, 1, 0));
      vecs.push_back(mkVec(0, 8'h00, 1, 0, 0, 1, 0, 0, 1));
      // J9, Backspace, J4
      vecs.push_back(mkVec(1, 8'h3B, 0, 0, 9, 1, 1, 0, 1));
      vecs.push_back(mkVec(1, 8'h46, 0, 0, 9, 9, 1, 1, 1));
      vecs.push_back(mkVec(1, 8'h66, 0, 0, 9, 9, 1, 0, 1));
      vecs.push_back(mkVec(1, 8'h25, 0, 0, 9, 4, 1, 1, 1));
      vecs.push_back(mkVec(1, 8'h5A, 0, 1, 9, 4, 1, 1, 1));
      vecs.push_back(mkVec(0, 8'h00, 1, 0, 9, 4, 0, 0, 0));
      // Extended keys and Enter in IDLE do nothing
      vecs.push_back(mkVec(1, 8'hE0, 0, 0, 9, 4, 0, 0, 0));
      vecs.push_back(mkVec(1, 8'h75, 0, 0, 9, 4, 0, 0, 0));
      vecs.push_back(mkVec(1, 8'hE0, 0, 0, 9, 4, 0, 0, 0));
      vecs.push_back(mkVec(1, 8'hF0, 0, 0, 9, 4, 0, 0, 0));
      vecs.push_back(mkVec(1, 8'h75, 0, 0, 9, 4, 0, 0, 0));
      vecs.push_back(mkVec(1, 8'h5A, 0, 0, 9, 4, 0, 0, 0));
      // B8 fired, repeat Enter and letter ignored, byte during acceptance
      vecs.push_back(mkVec(1, 8'h32, 0, 0, 1, 4, 1, 0, 0));
      vecs.push_back(mkVec(1, 8'h3E, 0, 0, 1, 8, 1, 1, 0));
      vecs.push_back(mkVec(1, 8'h5A, 0, 1, 1, 8, 1, 1, 0));
      vecs.push_back(mkVec(1, 8'h5A, 0, 1, 1, 8, 1, 1, 0));
      vecs.push_back(mkVec(1, 8'h32, 0, 1, 1, 8, 1, 1, 0));
      vecs.push_back(mkVec(1, 8'h1C, 1, 0, 1, 8, 0, 0, 1));
      vecs.push_back(mkVec(0, 8'h00, 1, 0, 1, 8, 0, 0, 1));
      vecs.push_back(mkVec(0, 8'h00, 0, 0, 1, 8, 0, 0, 1));
      // Enter with only a row is ignored; Backspace clears the row
      vecs.push_back(mkVec(1, 8'h1C, 0, 0, 0, 8, 1, 0, 1));
      vecs.push_back(mkVec(1, 8'h5A, 0, 0, 0, 8, 1, 0, 1));
      vecs.push_back(mkVec(1, 8'h66, 0, 0, 0, 8, 0, 0, 1));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].kv, vecs[i].kd, vecs[i].rdy);
         checkOutput($sformatf("vec%0d.valid", i), shot_valid, vecs[i].eValid);
         checkOutput($sformatf("vec%0d.row", i), shot_row, vecs[i].eRow);
         checkOutput($sformatf("vec%0d.col", i), shot_col, vecs[i].eCol);
         checkOutput($sformatf("vec%0d.have_row", i), have_row, vecs[i].eHr);
         checkOutput($sformatf("vec%0d.have_col", i), have_col, vecs[i].eHc);
         checkOutput($sformatf("vec%0d.turn", i), player_turn, vecs[i].eTurn);
      end

      // Asynchronous reset mid-HAVE_BOTH (turn is currently 1)
      applyStimulus(1, 8'h24, 0);
      applyStimulus(1, 8'h26, 0);
      #2; reset_n = 1'b0; #1;
      modelReset();
      checkOutput("areset1.turn", player_turn, 0);
      checkModel("areset1");
      #2; reset_n = 1'b1;
      @(negedge clock27);
      // Asynchronous reset while a shot is pending
      applyStimulus(1, 8'h24, 0);
      applyStimulus(1, 8'h26, 0);
      applyStimulus(1, 8'h5A, 0);
      checkOutput("areset2.pre_valid", shot_valid, 1);
      #2; reset_n = 1'b0; #1;
      modelReset();
      checkModel("areset2");
      #2; reset_n = 1'b1;
      @(negedge clock27);

`ifdef SHOT_TIMEOUT_EN
      applyStimulus(1, 8'h24, 0);
      for (int i = 0; i < TO_CYC - 1; i++) applyStimulus(0, 8'h00, 0);
      checkOutput("timeout.before", have_row, 1);
      applyStimulus(0, 8'h00, 0);
      checkOutput("timeout.fired", have_row, 0);
      checkOutput("timeout.row_kept", shot_row, 4);
      applyStimulus(1, 8'h24, 0);
      for (int i = 0; i < 9; i++) applyStimulus(0, 8'h00, 0);
      applyStimulus(1, 8'h12, 0);
      for (int i = 0; i < TO_CYC - 1; i++) applyStimulus(0, 8'h00, 0);
      checkOutput("timeout.restart_before", have_row, 1);
      applyStimulus(0, 8'h00, 0);
      checkOutput("timeout.restart_fired", have_row, 0);
`else
      applyStimulus(1, 8'h24, 0);
      for (int i = 0; i < 3 * TO_CYC; i++) applyStimulus(0, 8'h00, 0);
      checkOutput("no_timeout.have_row", have_row, 1);
      applyStimulus(1, 8'h66, 0);
`endif
      checkModel("post_timeout");

      // Randomized keystrokes against the model
      for (int i = 0; i < 3000; i++) begin
         bit kv, rdy;
         logic [7:0] kd;
         kv  = ($urandom_range(0, 99) < 45);
         kd  = pool[$urandom_range(0, 15)];
         rdy = ($urandom_range(0, 99) < 25);
         applyStimulus(kv, kd, rdy);
         checkModel($sformatf("rand%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/shot_entry_fsm.md
Name: shot_entry_fsm

Overview:
Converts the PS/2 byte stream from the keyboard controller into one validated shot coordinate: row letter A-J, then column digit 0-9, then Enter. It sits directly upstream of the hit/miss decider and hands each shot over with a valid/ready handshake. It owns the player-turn register, which toggles on every accepted shot and is exported to the VGA and hex stages. It also exports partial-entry status for the hex display.

Parameters:
TIMEOUT_CYCLES, 27000000, idle clocks before a partial entry is discarded; used only with SHOT_TIMEOUT_EN.
FIRST_PLAYER, 0, player_turn value after reset.

Ports:
clock27  in  1  system clock, 27 MHz
reset_n  in  1  asynchronous, active-low reset
key_valid  in  1  one-cycle strobe: new scan byte on key_data
key_data  in  8  PS/2 scan byte: make, F0 break prefix, or E0 extended prefix
shot_valid  out  1  coordinate held and ready for decider
shot_ready  in  1  decider accepts shot this cycle
shot_row  out  4  row index 0-9 (A=0 … J=9)
shot_col  out  4  column index 0-9
player_turn  out  1  current player; toggles on every accepted shot
have_row  out  1  row latched; hex display shows row
have_col  out  1  column latched; hex display shows column

Behaviour:
- Reset (async, reset_n=0): state=IDLE; shot_valid=0; shot_row=0; shot_col=0; have_row=0; have_col=0; player_turn=FIRST_PLAYER; break_pend=0; ext_pend=0; timeout counter=0.
- Byte filter, evaluated only on cycles with key_valid=1:
  - 0xF0: set break_pend; the byte is consumed.
  - 0xE0: set ext_pend; the byte is consumed.
  - Any other byte with break_pend or ext_pend set: clear both flags; the byte is discarded. This drops all releases and all extended keys, including F0 after E0 (E0 F0 xx: the F0 clears ext_pend, then xx is discarded under break_pend).
  - Any other byte with both flags clear is a "press", passed to the FSM.
- Press decode:
  - Letters: 1C,32,21,23,24,2B,34,33,43,3B give rows 0-9 (A-J).
  - Digits: 45,16,1E,26,25,2E,36,3D,3E,46 give columns 0-9.
  - Enter = 5A; Backspace = 66. All other codes are ignored.
- FSM transitions on a press:
  - IDLE: letter latches shot_row, then HAVE_ROW. Everything else is ignored.
  - HAVE_ROW: letter overwrites shot_row. Digit latches shot_col, then HAVE_BOTH. Backspace goes to IDLE. Enter is ignored.
  - HAVE_BOTH: letter overwrites shot_row and goes to HAVE_ROW, with the column dropped. Digit overwrites shot_col. Backspace goes to HAVE_ROW. Enter goes to FIRE.
  - FIRE: all presses are ignored; the prefix flags still track.
- Status outputs are registered with the same-cycle update as the state:
  - have_row=1 in HAVE_ROW, HAVE_BOTH and FIRE.
  - have_col=1 in HAVE_BOTH and FIRE.
- Handshake:
  - shot_valid is registered and rises in the cycle after the Enter press.
  - While valid, shot_row and shot_col are held stable; shot_valid stays high until shot_ready.
  - On a cycle with shot_valid && shot_ready: next cycle shot_valid=0, state=IDLE, have_row=have_col=0, and player_turn toggles. Only one toggle per accepted shot.
  - shot_ready while shot_valid=0 has no effect.
- Typematic repeat makes are treated as fresh presses. A repeat Enter in FIRE is ignored, so exactly one shot is produced.
- A key_valid byte arriving in the same cycle as acceptance is processed against the FIRE state and ignored (only prefix flags update).

Optional Feature:
SHOT_TIMEOUT_EN
- Defined:
  - A counter, sized to the bit width of TIMEOUT_CYCLES, runs while state is HAVE_ROW or HAVE_BOTH.
  - It clears on any key_valid and on entry to those states.
  - When it reaches TIMEOUT_CYCLES-1: next cycle state=IDLE and have_row=have_col=0.
  - Latched shot_row/shot_col keep their values; only the status flags clear.
  - No timeout in IDLE or FIRE.
- Undefined: no counter logic; a partial entry persists indefinitely.

Decomposition:
- Shared package battleship_pkg holds:
  - Scan-code constants: SC_BREAK=F0, SC_EXT=E0, SC_ENTER=5A, SC_BKSP=66, and the letter and digit code lists.
  - State enum: IDLE, HAVE_ROW, HAVE_BOTH, FIRE.
  - BOARD_SIZE=10, PLAYER_ONE=0, PLAYER_TWO=1.
- One combinational sub-module, scan_decode: key_data -> is_letter, is_digit, is_enter, is_bksp, index[3:0].

Test Plan:
1. Reset, then bytes 1C,F0,1C,16,F0,16,5A (Enter) -> after Enter: shot_valid=1, row=0, col=1. Hold shot_ready=0 for 5 clocks -> outputs stable. Pulse shot_ready -> shot_valid=0, player_turn 0→1.
2. Bytes 3B,46,66 (Backspace),25,5A -> row=9, col=4 (the Backspace drops the first column); have_col goes 1→0→1.
3. E0,75 (up arrow), E0,F0,75, then 5A in IDLE -> no state change; have_row=0; shot_valid=0.
4. Full shot reaching FIRE, then repeat Enter plus letter 32 before ready -> row and col unchanged. Accept -> exactly one player_turn toggle.
5. reset_n low mid-HAVE_BOTH, and again while shot_valid=1 -> all outputs take their reset values immediately (asynchronous, no clock needed).
6. SHOT_TIMEOUT_EN with TIMEOUT_CYCLES=16: letter 24, then idle 16 clocks -> have_row=0 at cycle 16. Repeat with a key byte at cycle 10 -> no timeout until 16 cycles after that byte.
